// File: rtl/cart_bus_arbiter.sv
// Cartridge bus arbiter: round-robin CPU/DMA sharing with timed SETUP/STROBE/HOLD phases.
// Ack is registered SETUP+STROBE+HOLD cycles after grant; a requester waits by holding req.
module cart_bus_arbiter #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_oe,
  input  logic [7:0]  bus_rdata,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_cs_n,
  output logic        busy
);
  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} grant_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  grant_t        grant_q, grant_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    cap_q, cap_d;
  logic          oe_q, oe_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    dma_rdata_q, dma_rdata_d;
  logic          pick_cpu, active, strobe, last_hold;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    // grant_q doubles as the round-robin history: the other side wins a tie
    pick_cpu = cpu_req && (!dma_req || grant_q == GNT_DMA);
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          grant_d = pick_cpu ? GNT_CPU : GNT_DMA;
          addr_d  = pick_cpu ? cpu_addr : dma_addr;
          we_d    = pick_cpu && cpu_we;
          if (pick_cpu) wdata_d = cpu_wdata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          cap_d   = bus_rdata;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins are flop-driven
    active    = (state_d != ST_IDLE);
    strobe    = (state_d == ST_STROBE);
    last_hold = (state_d == ST_HOLD) && (cnt_d == '0);
    oe_d      = active && we_d;
    rd_n_d    = !(strobe && !we_d);
    wr_n_d    = !(strobe && we_d);
    cs_n_d    = !(active && addr_d[15:13] == 3'b101);
    busy_d    = active;
    cpu_ack_d = last_hold && (grant_d == GNT_CPU);
    dma_ack_d = last_hold && (grant_d == GNT_DMA);
    // cap_d already holds bus_rdata when HOLD is a single cycle
    cpu_rdata_d = (cpu_ack_d && !we_d) ? cap_d : cpu_rdata_q;
    dma_rdata_d = dma_ack_d ? cap_d : dma_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= GNT_DMA;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      oe_q        <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      oe_q        <= oe_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_oe    = oe_q;
  assign bus_rd_n  = rd_n_q;
  assign bus_wr_n  = wr_n_q;
  assign bus_cs_n  = cs_n_q;
  assign busy      = busy_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter: vector table, hand sequences for contention, reset and
// single-cycle phases, then random rounds checked against a phase-arithmetic model.
module tb_cart_bus_arbiter;
  localparam int S = 2, T = 4, H = 1;
  localparam int LAT = S + T + H;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, dma_req, dma_ack;
  logic [15:0] cpu_addr, dma_addr, bus_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, dma_rdata, bus_wdata, bus_rdata;
  logic        bus_oe, bus_rd_n, bus_wr_n, bus_cs_n, busy;

  logic        f_cpu_req, f_cpu_we, f_cpu_ack, f_dma_req, f_dma_ack;
  logic [15:0] f_cpu_addr, f_dma_addr, f_bus_addr;
  logic [7:0]  f_cpu_wdata, f_cpu_rdata, f_dma_rdata, f_bus_wdata, f_bus_rdata;
  logic        f_bus_oe, f_bus_rd_n, f_bus_wr_n, f_bus_cs_n, f_busy;

  always #5 clk = ~clk;

  cart_bus_arbiter #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_oe(bus_oe), .bus_rdata(bus_rdata),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_cs_n(bus_cs_n), .busy(busy)
  );

  cart_bus_arbiter #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst),
    .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
    .cpu_ack(f_cpu_ack), .cpu_rdata(f_cpu_rdata),
    .dma_req(f_dma_req), .dma_addr(f_dma_addr), .dma_ack(f_dma_ack), .dma_rdata(f_dma_rdata),
    .bus_addr(f_bus_addr), .bus_wdata(f_bus_wdata), .bus_oe(f_bus_oe), .bus_rdata(f_bus_rdata),
    .bus_rd_n(f_bus_rd_n), .bus_wr_n(f_bus_wr_n), .bus_cs_n(f_bus_cs_n), .busy(f_busy)
  );

  typedef struct packed {
    logic        dma;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd_strb;
    logic [7:0]  rd_hold;
    logic        exp_cs_n;
    logic        exp_oe;
    logic [7:0]  exp_rdata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        model_last_cpu;
  logic [15:0] last_addr;
  logic [7:0]  exp_cpu_rd, exp_dma_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // p = phase cycle within a transaction (1..LAT), 0 when idle
  task automatic chk_bus(input int p, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd);
    logic act, strb;
    act  = (p != 0);
    strb = (p > S) && (p <= S + T);
    chk("busy", busy, act);
    chk("bus_cs_n", bus_cs_n, !(act && addr[15:13] == 3'b101));
    chk("bus_oe", bus_oe, act && we);
    chk("bus_rd_n", bus_rd_n, !(strb && !we));
    chk("bus_wr_n", bus_wr_n, !(strb && we));
    chk("bus_addr", bus_addr, addr);
    if (act && we) chk("bus_wdata", bus_wdata, wd);
  endtask

  task automatic model_reset();
    model_last_cpu = 1'b0;
    last_addr      = 16'h0000;
    exp_cpu_rd     = 8'h00;
    exp_dma_rd     = 8'h00;
  endtask

  // Caller is at a negedge with the arbiter idle; that cycle is cycle 0.
  task automatic run_txn(input vec_t v);
    int p;
    if (v.dma) begin
      dma_req = 1'b1; dma_addr = v.addr;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    bus_rdata = v.rd_hold;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      p = (c <= LAT) ? c : 0;
      chk_bus(p, v.we, v.addr, v.wdata);
      if (c == 1) begin
        chk("vec_cs_n", bus_cs_n, v.exp_cs_n);
        chk("vec_oe", bus_oe, v.exp_oe);
      end
      if (c == LAT) begin
        if (!v.we) begin
          if (v.dma) exp_dma_rd = v.exp_rdata;
          else       exp_cpu_rd = v.exp_rdata;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      chk("cpu_ack", cpu_ack, (c == LAT) && !v.dma);
      chk("dma_ack", dma_ack, (c == LAT) && v.dma);
      chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
      chk("dma_rdata", dma_rdata, exp_dma_rd);
      bus_rdata = (c > S && c <= S + T) ? v.rd_strb : v.rd_hold;
    end
    model_last_cpu = !v.dma;
    last_addr      = v.addr;
  endtask

  task automatic contention();
    int cc, dc;
    cc = -1;
    dc = -1;
    cpu_we = 1'b0; cpu_addr = 16'h0001; dma_addr = 16'h0002; bus_rdata = 8'hC3;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cpu_ack && cc < 0) begin cc = c; cpu_req = 1'b0; end
      if (dma_ack && dc < 0) begin dc = c; dma_req = 1'b0; end
      if (cc >= 0 && dc >= 0) break;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    chk("contention_cpu_ack_cycle", cc, LAT);
    chk("contention_dma_ack_cycle", dc, 2 * LAT + 1);
    @(negedge clk);
    exp_cpu_rd = 8'hC3;
    exp_dma_rd = 8'hC3;
    chk("contention_cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("contention_dma_rdata", dma_rdata, exp_dma_rd);
    model_last_cpu = 1'b0;
    last_addr      = 16'h0002;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 2) == 0) a[15:13] = 3'b101;
    return a;
  endfunction

  task automatic rnd_round();
    logic [1:0]  which;
    logic        first_cpu;
    logic        t_cpu [2];
    logic        t_we  [2];
    logic [15:0] t_addr[2];
    logic [7:0]  t_wd  [2];
    logic [7:0]  rv    [17];
    int          n, k, p;
    which     = 2'($urandom_range(1, 3));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = rnd_addr();
    cpu_wdata = 8'($urandom);
    dma_addr  = rnd_addr();
    n         = (which == 2'b11) ? 2 : 1;
    first_cpu = (which == 2'b11) ? !model_last_cpu : which[0];
    t_cpu[0]  = first_cpu;
    t_cpu[1]  = !first_cpu;
    for (int i = 0; i < 2; i++) begin
      t_we[i]   = t_cpu[i] ? cpu_we : 1'b0;
      t_addr[i] = t_cpu[i] ? cpu_addr : dma_addr;
      t_wd[i]   = cpu_wdata;
    end
    cpu_req   = which[0];
    dma_req   = which[1];
    rv[0]     = 8'($urandom);
    bus_rdata = rv[0];
    for (int c = 1; c <= n * (LAT + 1); c++) begin
      @(negedge clk);
      k = (c - 1) / (LAT + 1);
      p = (c - 1) % (LAT + 1) + 1;
      if (p == LAT + 1) p = 0;
      chk_bus(p, t_we[k], (p == 0) ? t_addr[k] : t_addr[k], t_wd[k]);
      if (p == LAT) begin
        if (!t_we[k]) begin
          if (t_cpu[k]) exp_cpu_rd = rv[k * (LAT + 1) + S + T];
          else          exp_dma_rd = rv[k * (LAT + 1) + S + T];
        end
        if (t_cpu[k]) cpu_req = 1'b0;
        else          dma_req = 1'b0;
        model_last_cpu = t_cpu[k];
        last_addr      = t_addr[k];
      end
      chk("rnd_cpu_ack", cpu_ack, (p == LAT) && t_cpu[k]);
      chk("rnd_dma_ack", dma_ack, (p == LAT) && !t_cpu[k]);
      chk("rnd_cpu_rdata", cpu_rdata, exp_cpu_rd);
      chk("rnd_dma_rdata", dma_rdata, exp_dma_rd);
      if (p >= 1 && p < LAT) begin
        if (t_cpu[k]) begin
          cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom_range(0, 1));
        end else begin
          dma_addr = 16'($urandom);
        end
      end
      rv[c]     = 8'($urandom);
      bus_rdata = rv[c];
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t rd_after;
    tbl[0] = '{1'b0, 1'b0, 16'h0150, 8'h00, 8'h3C, 8'hE1, 1'b1, 1'b0, 8'h3C};
    tbl[1] = '{1'b0, 1'b1, 16'hA010, 8'h55, 8'h99, 8'h66, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 16'h4000, 8'h00, 8'hAA, 8'h11, 1'b1, 1'b0, 8'hAA};
    tbl[3] = '{1'b1, 1'b0, 16'hA123, 8'h00, 8'h5A, 8'hA5, 1'b0, 1'b0, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 16'hBFFF, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h0F};
    tbl[5] = '{1'b0, 1'b1, 16'hC000, 8'hF0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 16'h9FFF, 8'h01, 8'h77, 8'h88, 1'b1, 1'b1, 8'h00};
    rd_after = '{1'b0, 1'b0, 16'h0150, 8'h00, 8'h77, 8'h00, 1'b1, 1'b0, 8'h77};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; bus_rdata = '0;
    f_cpu_req = 1'b0; f_cpu_we = 1'b0; f_cpu_addr = '0; f_cpu_wdata = '0;
    f_dma_req = 1'b0; f_dma_addr = '0; f_bus_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);

    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_n", bus_rd_n, 1'b1);
    chk("rst_wr_n", bus_wr_n, 1'b1);
    chk("rst_cs_n", bus_cs_n, 1'b1);
    chk("rst_oe", bus_oe, 1'b0);
    chk("rst_addr", bus_addr, 16'h0000);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_dma_ack", dma_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_dma_rdata", dma_rdata, 8'h00);
    chk("rst_fast_busy", f_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    contention();
    contention();

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Reset in the second STROBE cycle of a write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA010; cpu_wdata = 8'h55;
    repeat (4) @(negedge clk);
    chk("pre_rst_wr_n", bus_wr_n, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wr_n", bus_wr_n, 1'b1);
    chk("midrst_oe", bus_oe, 1'b0);
    chk("midrst_cs_n", bus_cs_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cpu_ack", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst_cpu_ack_later", cpu_ack, 1'b0);
    chk("midrst_cpu_rdata", cpu_rdata, 8'h00);
    run_txn(rd_after);

    // Single-cycle phases: one access every 4 cycles
    f_cpu_req = 1'b1; f_cpu_we = 1'b0; f_cpu_addr = 16'hA000; f_bus_rdata = 8'h40;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("fast_cpu_ack", f_cpu_ack, (c % 4) == 3);
      chk("fast_rd_n", f_bus_rd_n, (c % 4) != 2);
      chk("fast_busy", f_busy, (c % 4) != 0);
      chk("fast_cs_n", f_bus_cs_n, (c % 4) == 0);
      if ((c % 4) == 3) chk("fast_cpu_rdata", f_cpu_rdata, 32'(8'h40 + c - 1));
      f_bus_rdata = 8'(8'h40 + c);
      if (c == 16) f_cpu_req = 1'b0;
    end
    @(negedge clk);
    chk("fast_idle_busy", f_busy, 1'b0);

    for (int r = 0; r < 30; r++) rnd_round();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_bus_arbiter.md
Name: cart_bus_arbiter

Overview:
- Sequences every cartridge bus transaction through timed SETUP/STROBE/HOLD phases.
- Shares the single cartridge bus between two requesters: the CPU (read/write) and the OAM DMA engine (read-only).
- Sits between the CPU/DMA memory ports and the cartridge pin driver. It owns the strobe timing, chip-select decode and read-data capture.

Parameters:
- SETUP_CYCLES, 2: cycles address/data are stable before the strobe asserts (≥1).
- STROBE_CYCLES, 4: cycles rd_n/wr_n are held low (≥1). Read data is captured on the last one.
- HOLD_CYCLES, 1: cycles address/data are held after the strobe deasserts (≥1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  16  CPU address; sampled at grant.
- cpu_wdata  in  8  CPU write data; sampled at grant.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid with cpu_ack, held until the next CPU read completes.
- dma_req  in  1  DMA read request; held until dma_ack.
- dma_addr  in  16  DMA address; sampled at grant.
- dma_ack  out  1  one-cycle completion pulse.
- dma_rdata  out  8  read data; valid with dma_ack, held until the next DMA read completes.
- bus_addr  out  16  cartridge address.
- bus_wdata  out  8  cartridge write data.
- bus_oe  out  1  1 = drive the data pins with bus_wdata.
- bus_rdata  in  8  cartridge data pins as read back.
- bus_rd_n  out  1  active-low read strobe.
- bus_wr_n  out  1  active-low write strobe.
- bus_cs_n  out  1  active-low external-RAM chip select.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous; all outputs registered):
  - state IDLE, phase counter 0, last_grant = DMA.
  - bus_addr 0, bus_wdata 0, bus_oe 0, bus_rd_n 1, bus_wr_n 1, bus_cs_n 1.
  - acks 0, cpu_rdata 0, dma_rdata 0, busy 0.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE arbitration:
  - One request pending → grant it.
  - Both pending → grant the requester that is not last_grant (round-robin), so the CPU wins the first contention after reset.
  - At grant, latch address, write data and we (we forced to 0 for DMA), update last_grant, enter SETUP, load counter = SETUP_CYCLES-1.
- Phase transitions: each phase counts down to 0, then advances.
  - SETUP → STROBE, counter loaded with STROBE_CYCLES-1.
  - STROBE → HOLD, counter loaded with HOLD_CYCLES-1.
  - HOLD → IDLE.
- Bus outputs during SETUP/STROBE/HOLD:
  - bus_addr = latched address.
  - bus_cs_n = 0 iff latched addr[15:13] == 3'b101 (0xA000–0xBFFF).
  - Write: bus_oe = 1 and bus_wdata = latched data across all three phases.
- Strobes: bus_rd_n (read) or bus_wr_n (write) is 0 only during STROBE.
- Read capture: on the last STROBE cycle, capture bus_rdata into an internal register.
- Completion: on the last HOLD cycle, pulse the granted requester's ack for one cycle. For a read, load its rdata output in that same cycle.
- Latency: req seen in IDLE at cycle 0 → ack registered at cycle SETUP+STROBE+HOLD (7 with defaults). A one-cycle IDLE always follows, so back-to-back throughput is one access per 8 cycles.
- Request withdrawal: a requester must deassert req in the cycle after ack, otherwise a new transaction starts. If req drops mid-transaction, the transaction still completes and ack still pulses.
- Input sampling: inputs change freely after grant; only the values latched at grant are used.
- In IDLE: bus_addr holds its last value; strobes, bus_cs_n and bus_oe are inactive.
- Reset mid-transaction: strobes, bus_oe and bus_cs_n go inactive immediately (asynchronously), no ack is issued, and the FSM returns to IDLE.
- Counter width: $clog2(max(SETUP,STROBE,HOLD)+1). Parameter values of 1 yield single-cycle phases.

Test Plan:
1. CPU read 0x0150, bus_rdata = 0x3C → bus_rd_n low on cycles 3–6, bus_cs_n stays 1, bus_oe stays 0, cpu_ack at cycle 7 with cpu_rdata = 0x3C, busy high on cycles 1–7.
2. CPU write 0xA010 = 0x55 → bus_cs_n = 0 and bus_oe = 1 on cycles 1–7, bus_wdata = 0x55, bus_wr_n low on cycles 3–6, bus_rd_n stays 1, cpu_ack at cycle 7.
3. cpu_req and dma_req both asserted after reset and held → CPU is served first (ack at cycle 7), DMA next (dma_ack at cycle 15). When both re-request, the CPU is granted next.
4. DMA read 0x4000 with bus_rdata = 0xAA during STROBE, then 0x11 during HOLD → dma_rdata = 0xAA, and cpu_rdata is unchanged.
5. rst asserted in the second STROBE cycle of a write → bus_wr_n, bus_oe and bus_cs_n inactive before the next edge, no cpu_ack, busy 0. After release, a new read completes normally.
6. SETUP = STROBE = HOLD = 1, continuous cpu_req with req dropped one cycle after each ack → ack every 4 cycles, first ack at cycle 3, strobe low for exactly 1 cycle each transaction.
